// File: rtl/hazard_pkg.sv
// Shared encodings for the EX hazard scheduler: forwarding selects,
// sequencer states and the operand forwarding priority rule.
package hazard_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

  // The M-stage result is younger than W, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       regwrite_m,
                                         input logic [4:0] rd_m,
                                         input logic       regwrite_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != REG_ZERO) begin
      if (regwrite_m && (rd_m == rs))      sel = FWD_MEM;
      else if (regwrite_w && (rd_w == rs)) sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mc_seq_fsm.sv
// Occupancy sequencer for a multi-cycle EX op: holds the pipeline while the
// op runs, freezes the operand forwarding selects and flags the last cycle.
module mc_seq_fsm #(
  parameter int MC_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mc_start_i,
  input  logic [1:0] fwd_a_i,
  input  logic [1:0] fwd_b_i,
  output logic       mc_stall_o,
  output logic       mc_last_o,
  output logic       busy_o,
  output logic [1:0] held_a_o,
  output logic [1:0] held_b_o
);
  import hazard_pkg::*;

  localparam int CW = (MC_CYCLES > 2) ? $clog2(MC_CYCLES - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (MC_CYCLES > 1) ? CW'(MC_CYCLES - 2) : '0;

  mc_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    held_a_q, held_a_d, held_b_q, held_b_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      held_a_q <= FWD_RF;
      held_b_q <= FWD_RF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      held_a_q <= held_a_d;
      held_b_q <= held_b_d;
    end
  end

  // Operands are captured in the start cycle; later cycles reuse them.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    held_a_d   = held_a_q;
    held_b_d   = held_b_q;
    mc_stall_o = 1'b0;
    mc_last_o  = 1'b0;
    if (MC_CYCLES <= 1) begin
      mc_last_o = mc_start_i;
    end else begin
      case (state_q)
        IDLE: begin
          if (mc_start_i) begin
            state_d    = BUSY;
            cnt_d      = CNT_INIT;
            held_a_d   = fwd_a_i;
            held_b_d   = fwd_b_i;
            mc_stall_o = 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_d      = cnt_q - CW'(1);
            mc_stall_o = 1'b1;
          end else begin
            state_d   = IDLE;
            mc_last_o = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q == BUSY);
  assign held_a_o = held_a_q;
  assign held_b_o = held_b_q;

endmodule

// File: rtl/ex_hazard_sched.sv
// EX hazard scheduler: forwarding selects, load-use stall, control-flow flush
// and multi-cycle op hold. Optional perf counters under HAZ_PERF_CNT_EN.
module ex_hazard_sched #(
  parameter int MC_CYCLES = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic             load_e,
  input  logic             regwrite_m,
  input  logic [4:0]       rd_m,
  input  logic             regwrite_w,
  input  logic [4:0]       rd_w,
  input  logic             pcsrc_e,
  input  logic             mc_start_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             bubble_m,
  output logic             mc_last,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import hazard_pkg::*;

  logic [1:0] fwd_a, fwd_b, held_a, held_b;
  logic       mc_stall, mc_last_raw, mc_busy, load_use;

  assign fwd_a    = fwd_sel(rs1_e, regwrite_m, rd_m, regwrite_w, rd_w);
  assign fwd_b    = fwd_sel(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w);
  assign load_use = load_e && (rd_e != REG_ZERO) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  mc_seq_fsm #(.MC_CYCLES(MC_CYCLES)) u_mc_seq (
    .clk        (clk),
    .rst        (rst),
    .mc_start_i (mc_start_e),
    .fwd_a_i    (fwd_a),
    .fwd_b_i    (fwd_b),
    .mc_stall_o (mc_stall),
    .mc_last_o  (mc_last_raw),
    .busy_o     (mc_busy),
    .held_a_o   (held_a),
    .held_b_o   (held_b)
  );

  // Controls are gated by reset so they drop immediately, not at the next edge.
  always_comb begin
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    bubble_m    = 1'b0;
    mc_last     = 1'b0;
    if (rst) begin
      forward_a_e = mc_busy ? held_a : fwd_a;
      forward_b_e = mc_busy ? held_b : fwd_b;
      mc_last     = mc_last_raw;
      if (mc_stall) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        bubble_m = 1'b1;
      end else if (pcsrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_e && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_sched.sv
// Self-checking bench for ex_hazard_sched: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_ex_hazard_sched;

  localparam int MC    = 4;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          load_e, regwrite_m, regwrite_w, pcsrc_e, mc_start_e;
  logic [1:0]    forward_a_e, forward_b_e;
  logic          stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, mc_last;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ex_hazard_sched #(.MC_CYCLES(MC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .load_e(load_e), .regwrite_m(regwrite_m), .rd_m(rd_m),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .pcsrc_e(pcsrc_e), .mc_start_e(mc_start_e),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .bubble_m(bubble_m), .mc_last(mc_last),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_rem;           // EX cycles of the multi-cycle op still to run after now
  logic [1:0] m_ha, m_hb;
  int         m_sc, m_fc;
  int         n_rem, n_sc, n_fc;
  logic [1:0] n_ha, n_hb;

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (regwrite_m && rd_m == rs) return 2'b10;
    if (regwrite_w && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rem = 0; m_ha = 2'b00; m_hb = 2'b00; m_sc = 0; m_fc = 0;
    end else begin
      m_rem = n_rem; m_ha = n_ha; m_hb = n_hb; m_sc = n_sc; m_fc = n_fc;
    end
  end

  always @(negedge clk) begin
    bit         hold, last, lu;
    logic [1:0] ea, eb;
    int         sf, sd, se, fd, fe, bm, ml;
    sf = 0; sd = 0; se = 0; fd = 0; fe = 0; bm = 0; ml = 0; ea = 2'b00; eb = 2'b00;
    n_rem = 0; n_ha = 2'b00; n_hb = 2'b00; n_sc = 0; n_fc = 0;
    if (rst) begin
      hold = (m_rem == 0 && mc_start_e && MC > 1) || (m_rem > 1);
      last = (m_rem == 1) || (MC == 1 && mc_start_e);
      lu   = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      ea   = (m_rem > 0) ? m_ha : m_fwd(rs1_e);
      eb   = (m_rem > 0) ? m_hb : m_fwd(rs2_e);
      ml   = int'(last);
      if (hold)         begin sf = 1; sd = 1; se = 1; bm = 1; end
      else if (pcsrc_e) begin fd = 1; fe = 1; end
      else if (lu)      begin sf = 1; sd = 1; fe = 1; end
      n_ha = m_ha; n_hb = m_hb;
      if (m_rem == 0 && mc_start_e && MC > 1) begin
        n_rem = MC - 1; n_ha = m_fwd(rs1_e); n_hb = m_fwd(rs2_e);
      end else if (m_rem > 0) begin
        n_rem = m_rem - 1;
      end
      n_sc = (m_sc + sf > CMAX) ? CMAX : m_sc + sf;
      n_fc = (m_fc + fe > CMAX) ? CMAX : m_fc + fe;
    end
    chk("fwd_a", int'(forward_a_e), int'(ea));
    chk("fwd_b", int'(forward_b_e), int'(eb));
    chk("stall_f", int'(stall_f), sf);
    chk("stall_d", int'(stall_d), sd);
    chk("stall_e", int'(stall_e), se);
    chk("flush_d", int'(flush_d), fd);
    chk("flush_e", int'(flush_e), fe);
    chk("bubble_m", int'(bubble_m), bm);
    chk("mc_last", int'(mc_last), ml);
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", int'(stall_cnt), rst ? m_sc : 0);
    chk("flush_cnt", int'(flush_cnt), rst ? m_fc : 0);
`else
    chk("stall_cnt", int'(stall_cnt), 0);
    chk("flush_cnt", int'(flush_cnt), 0);
`endif
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; regwrite_m = 0; regwrite_w = 0; pcsrc_e = 0; mc_start_e = 0;
  endtask

  task automatic chk_ctl(input string nm, input int sf, input int sd, input int se,
                         input int fd, input int fe, input int bm, input int ml);
    chk({nm, ".stall_f"}, int'(stall_f), sf);
    chk({nm, ".stall_d"}, int'(stall_d), sd);
    chk({nm, ".stall_e"}, int'(stall_e), se);
    chk({nm, ".flush_d"}, int'(flush_d), fd);
    chk({nm, ".flush_e"}, int'(flush_e), fe);
    chk({nm, ".bubble_m"}, int'(bubble_m), bm);
    chk({nm, ".mc_last"}, int'(mc_last), ml);
  endtask

  initial begin
    clr();
    rst = 1'b0;
    step(); step();
    #1;
    chk_ctl("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.fwd_a", int'(forward_a_e), 0);
    chk("reset.stall_cnt", int'(stall_cnt), 0);
    rst = 1'b1;
    step();

    // multi-cycle op: 3 stall cycles, mc_last in the 4th, selects frozen
    mc_start_e = 1; rs1_e = 3; rs2_e = 4; regwrite_m = 1; rd_m = 3; regwrite_w = 1; rd_w = 4;
    #1;
    chk_ctl("mc.c1", 1, 1, 1, 0, 0, 1, 0);
    chk("mc.c1.fwd_a", int'(forward_a_e), 2);
    chk("mc.c1.fwd_b", int'(forward_b_e), 1);
    step();
    rd_m = 9; rd_w = 9;
    #1;
    chk_ctl("mc.c2", 1, 1, 1, 0, 0, 1, 0);
    chk("mc.c2.fwd_a_held", int'(forward_a_e), 2);
    chk("mc.c2.fwd_b_held", int'(forward_b_e), 1);
    step(); #1;
    chk_ctl("mc.c3", 1, 1, 1, 0, 0, 1, 0);
    step(); #1;
    chk_ctl("mc.c4", 0, 0, 0, 0, 0, 0, 1);
    chk("mc.c4.fwd_a_held", int'(forward_a_e), 2);
    step();
    mc_start_e = 0;
    #1;
    chk_ctl("mc.idle", 0, 0, 0, 0, 0, 0, 0);
    chk("mc.idle.fwd_a", int'(forward_a_e), 0);
`ifdef HAZ_PERF_CNT_EN
    chk("mc.stall_cnt", int'(stall_cnt), 3);
`else
    chk("mc.stall_cnt", int'(stall_cnt), 0);
`endif

    // forwarding priority
    clr();
    rs1_e = 5; regwrite_m = 1; rd_m = 5; regwrite_w = 1; rd_w = 5;
    #1; chk("fwd.m_beats_w", int'(forward_a_e), 2);
    step();
    rd_m = 0;
    #1; chk("fwd.w_only", int'(forward_a_e), 1);
    step();
    rs1_e = 0; rd_m = 0; rd_w = 0;
    #1; chk("fwd.x0", int'(forward_a_e), 0);
    step();

    // load-use
    clr();
    load_e = 1; rd_e = 7; rs2_d = 7;
    #1; chk_ctl("lu", 1, 1, 0, 0, 1, 0, 0);
    step();
    load_e = 0;
    #1; chk_ctl("lu.after", 0, 0, 0, 0, 0, 0, 0);
    step();

    // load-use with taken branch: flush only
    load_e = 1; rd_e = 7; rs2_d = 7; pcsrc_e = 1;
    #1; chk_ctl("lu_br", 0, 0, 0, 1, 1, 0, 0);
    step();
    clr();

    // asynchronous reset in the 2nd BUSY cycle
    mc_start_e = 1;
    step(); step();
    #1; chk_ctl("rstmc.busy2", 1, 1, 1, 0, 0, 1, 0);
    rst = 1'b0;
    #1; chk_ctl("rstmc.async", 0, 0, 0, 0, 0, 0, 0);
    chk("rstmc.stall_cnt", int'(stall_cnt), 0);
    step();
    mc_start_e = 0; rst = 1'b1;
    #1; chk_ctl("rstmc.release", 0, 0, 0, 0, 0, 0, 0);
    step();
    #1; chk_ctl("rstmc.idle", 0, 0, 0, 0, 0, 0, 0);

    // random traffic, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
      rd_w  = 5'($urandom_range(0, 3));
      load_e     = ($urandom_range(0, 9) < 3);
      regwrite_m = ($urandom_range(0, 1) == 1);
      regwrite_w = ($urandom_range(0, 1) == 1);
      pcsrc_e    = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 9) < 2) mc_start_e = ~mc_start_e;
      rst = ($urandom_range(0, 599) != 0);
      step();
    end
    rst = 1'b1;
    clr();
    step();

    // long load-use stream drives the stall counter into saturation
    load_e = 1; rd_e = 2; rs1_d = 2;
    repeat (CMAX + 8) step();
    #1;
`ifdef HAZ_PERF_CNT_EN
    chk("sat.stall_cnt", int'(stall_cnt), CMAX);
    chk("sat.flush_cnt", int'(flush_cnt), CMAX);
`else
    chk("sat.stall_cnt", int'(stall_cnt), 0);
    chk("sat.flush_cnt", int'(flush_cnt), 0);
`endif
    clr();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
